dq_tablo_kontrol: RTL and testbench

//  Quantization-table manager and block scheduler for the dequantizer.
//  - Loads 8-bit DQT segment payloads (Pq/Tq header + 64 zigzag-ordered bytes) from the header parser into a 4-table store.
//  - Tracks the MCU block sequence and selects the active table per block.
//  - Answers per-coefficient (row,col) lookups from the dequantizer with 1-cycle latency.

---
 rtl/dq_tablo_kontrol.sv | 181 ++++++++++++++++++
 tb/tb_dq_tablo_kontrol.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dq_tablo_kontrol.sv
// Dequantizer quantization-table store, DQT payload loader and MCU block scheduler.
// Answers (row,col) lookups one cycle after the request for the table selected by the current block.
module dq_tablo_kontrol #(
  parameter int TABLO_SAYISI = 4,
  parameter int DQ_TABLO_BIT = 8,
  parameter int BLOCK_BIT    = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    dqt_veri_i,
  input  logic                          dqt_gecerli_i,
  output logic                          dqt_hazir_o,
  output logic                          dqt_tablo_son_o,
  output logic                          dqt_hata_o,
  input  logic [2:0]                    cfg_y_blok_i,
  input  logic [1:0]                    cfg_bilesen_i,
  input  logic [3*$clog2(TABLO_SAYISI)-1:0] cfg_tablo_i,
  input  logic                          cerceve_bas_i,
  input  logic [BLOCK_BIT-1:0]          sorgu_row_i,
  input  logic [BLOCK_BIT-1:0]          sorgu_col_i,
  input  logic                          sorgu_gecerli_i,
  input  logic                          sorgu_blok_son_i,
  output logic [DQ_TABLO_BIT-1:0]       sorgu_deger_o,
  output logic                          sorgu_gecerli_o,
  output logic [1:0]                    aktif_bilesen_o,
  output logic [$clog2(TABLO_SAYISI)-1:0] aktif_tablo_o,
  output logic [1:0]                    dbg_durum_o
);

  localparam int TQ_BIT = $clog2(TABLO_SAYISI);
  localparam int AW     = TQ_BIT + 2 * BLOCK_BIT;

  // Zigzag position k -> natural index row*8+col.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    YUKLE = 2'd1,
    ATLA  = 2'd2
  } durum_t;

  durum_t                  r_durum;
  logic [6:0]              r_sayac;
  logic [TQ_BIT-1:0]       r_tq;
  logic [TABLO_SAYISI-1:0] r_yuklu;
  logic                    r_hazir;
  logic                    r_son;
  logic                    r_hata;
  logic [DQ_TABLO_BIT-1:0] r_ram [0:2**AW-1];
  logic [DQ_TABLO_BIT-1:0] r_deger;
  logic                    r_sorgu_gec;
  logic [2:0]              r_blk;

  logic                    w_kabul;
  logic [3:0]              w_pq;
  logic [3:0]              w_tq_hdr;
  logic                    w_yaz;
  logic [AW-1:0]           w_yaz_adr;
  logic [AW-1:0]           w_oku_adr;
  logic                    w_ilerle;
  logic [3:0]              w_son_blk;
  logic [1:0]              w_bilesen;
  logic [TQ_BIT-1:0]       w_aktif_tablo;

  // Handshake: a DQT byte transfers on every rising edge where dqt_gecerli_i && dqt_hazir_o;
  // the producer holds dqt_veri_i stable while valid is high and hazir is low.
  assign w_kabul   = dqt_gecerli_i && r_hazir;
  assign w_pq      = dqt_veri_i[7:4];
  assign w_tq_hdr  = dqt_veri_i[3:0];
  assign w_yaz     = w_kabul && (r_durum == YUKLE);
  assign w_yaz_adr = {r_tq, ZZ[r_sayac[5:0]]};
  assign w_oku_adr = {w_aktif_tablo, sorgu_row_i, sorgu_col_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOSTA;
      r_sayac <= '0;
      r_tq    <= '0;
      r_yuklu <= '0;
      r_hazir <= 1'b0;
      r_son   <= 1'b0;
      r_hata  <= 1'b0;
    end else begin
      r_hazir <= 1'b1;
      r_son   <= 1'b0;
      case (r_durum)
        BOSTA: begin
          if (w_kabul) begin
            if ((w_pq == 4'd0) && (int'(w_tq_hdr) < TABLO_SAYISI)) begin
              r_durum <= YUKLE;
              r_sayac <= '0;
              r_tq    <= w_tq_hdr[TQ_BIT-1:0];
            end else begin
              // 16-bit precision (or any Pq!=0) payloads are twice as long.
              r_hata  <= 1'b1;
              r_durum <= ATLA;
              r_sayac <= (w_pq == 4'd0) ? 7'd63 : 7'd127;
            end
          end
        end
        YUKLE: begin
          if (w_kabul) begin
            if (r_sayac == 7'd63) begin
              r_yuklu[r_tq] <= 1'b1;
              r_son         <= 1'b1;
              r_durum       <= BOSTA;
            end else begin
              r_sayac <= r_sayac + 7'd1;
            end
          end
        end
        ATLA: begin
          if (w_kabul) begin
            if (r_sayac == 7'd0) r_durum <= BOSTA;
            else r_sayac <= r_sayac - 7'd1;
          end
        end
        default: r_durum <= BOSTA;
      endcase
    end
  end

  // Written alone so the store carries no reset; a same-edge read sees the old entry.
  always_ff @(posedge clk_i) begin
    if (w_yaz) r_ram[w_yaz_adr] <= dqt_veri_i;
  end

  assign w_ilerle  = sorgu_gecerli_i && sorgu_blok_son_i;
  assign w_son_blk = {1'b0, cfg_y_blok_i} + ((cfg_bilesen_i == 2'd3) ? 4'd2 : 4'd0) - 4'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_deger     <= '0;
      r_sorgu_gec <= 1'b0;
      r_blk       <= '0;
    end else begin
      r_sorgu_gec <= sorgu_gecerli_i;
      if (sorgu_gecerli_i) begin
        r_deger <= r_yuklu[w_aktif_tablo] ? r_ram[w_oku_adr] : DQ_TABLO_BIT'(1);
      end
      if (cerceve_bas_i) begin
        r_blk <= '0;
      end else if (w_ilerle) begin
        r_blk <= ({1'b0, r_blk} >= w_son_blk) ? 3'd0 : r_blk + 3'd1;
      end
    end
  end

  always_comb begin
    w_bilesen = 2'd0;
    if (r_blk >= cfg_y_blok_i) w_bilesen = r_blk[1:0] - cfg_y_blok_i[1:0] + 2'd1;
  end

  always_comb begin
    w_aktif_tablo = cfg_tablo_i[TQ_BIT-1:0];
    case (w_bilesen)
      2'd1:    w_aktif_tablo = cfg_tablo_i[2*TQ_BIT-1:TQ_BIT];
      2'd2:    w_aktif_tablo = cfg_tablo_i[3*TQ_BIT-1:2*TQ_BIT];
      default: w_aktif_tablo = cfg_tablo_i[TQ_BIT-1:0];
    endcase
  end

  assign dqt_hazir_o     = r_hazir;
  assign dqt_tablo_son_o = r_son;
  assign dqt_hata_o      = r_hata;
  assign sorgu_deger_o   = r_deger;
  assign sorgu_gecerli_o = r_sorgu_gec;
  assign aktif_bilesen_o = w_bilesen;
  assign aktif_tablo_o   = w_aktif_tablo;
  assign dbg_durum_o     = r_durum;

endmodule

// File: tb/tb_dq_tablo_kontrol.sv
// Bench for dq_tablo_kontrol: directed tables plus a random DQT/lookup stream checked
// against a table-level model of the loader, store and MCU block order.
module tb_dq_tablo_kontrol;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] dqt_veri_i;
  logic       dqt_gecerli_i;
  logic       dqt_hazir_o;
  logic       dqt_tablo_son_o;
  logic       dqt_hata_o;
  logic [2:0] cfg_y_blok_i;
  logic [1:0] cfg_bilesen_i;
  logic [5:0] cfg_tablo_i;
  logic       cerceve_bas_i;
  logic [2:0] sorgu_row_i;
  logic [2:0] sorgu_col_i;
  logic       sorgu_gecerli_i;
  logic       sorgu_blok_son_i;
  logic [7:0] sorgu_deger_o;
  logic       sorgu_gecerli_o;
  logic [1:0] aktif_bilesen_o;
  logic [1:0] aktif_tablo_o;
  logic [1:0] dbg_durum_o;

  dq_tablo_kontrol dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dqt_veri_i(dqt_veri_i), .dqt_gecerli_i(dqt_gecerli_i), .dqt_hazir_o(dqt_hazir_o),
    .dqt_tablo_son_o(dqt_tablo_son_o), .dqt_hata_o(dqt_hata_o),
    .cfg_y_blok_i(cfg_y_blok_i), .cfg_bilesen_i(cfg_bilesen_i), .cfg_tablo_i(cfg_tablo_i),
    .cerceve_bas_i(cerceve_bas_i),
    .sorgu_row_i(sorgu_row_i), .sorgu_col_i(sorgu_col_i), .sorgu_gecerli_i(sorgu_gecerli_i),
    .sorgu_blok_son_i(sorgu_blok_son_i), .sorgu_deger_o(sorgu_deger_o),
    .sorgu_gecerli_o(sorgu_gecerli_o), .aktif_bilesen_o(aktif_bilesen_o),
    .aktif_tablo_o(aktif_tablo_o), .dbg_durum_o(dbg_durum_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_son = 0;
  int n_req = 0;
  int n_resp = 0;
  logic [7:0] exp_q[$];

  // ---------------- reference model state ----------------
  int         zz_nat[64];
  logic [7:0] mdl_tab[4][64];
  bit   [3:0] mdl_yuklu;
  bit         mdl_hata;
  bit         mdl_hazir;
  int         mdl_blk;
  int         m_need;
  bit         m_ok;
  int         m_tq;
  int         m_pos;
  bit         e_son;
  bit         e_gec;
  bit         rst_seen;
  bit         last_acc;

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] exp;
  } lk_vec_t;
  lk_vec_t t1_vec[8];
  logic [1:0] t3_tab[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Zigzag order built by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz_nat[k] = r * 8 + (s - r); k++; end
      else            for (int r = lo; r <= hi; r++) begin zz_nat[k] = r * 8 + (s - r); k++; end
    end
  endfunction

  function automatic int mdl_n();
    return int'(cfg_y_blok_i) + ((cfg_bilesen_i == 2'd3) ? 2 : 0);
  endfunction

  function automatic int mdl_bil();
    return (mdl_blk < int'(cfg_y_blok_i)) ? 0 : mdl_blk - int'(cfg_y_blok_i) + 1;
  endfunction

  function automatic int mdl_tablo();
    return int'((cfg_tablo_i >> (2 * mdl_bil())) & 6'd3);
  endfunction

  // Segment byte stream: header, then 64 bytes (or 64/128 discarded on a bad header).
  function automatic void model_byte(input logic [7:0] b);
    if (m_need == 0) begin
      m_pos = 0;
      if (b[7:4] == 4'd0 && b[3:0] < 4'd4) begin
        m_ok = 1; m_tq = int'(b[3:0]); m_need = 64;
      end else begin
        m_ok = 0; mdl_hata = 1; m_need = (b[7:4] == 4'd0) ? 64 : 128;
      end
    end else begin
      if (m_ok) mdl_tab[m_tq][zz_nat[m_pos]] = b;
      m_pos++;
      m_need--;
      if (m_ok && m_need == 0) begin
        mdl_yuklu[m_tq] = 1'b1;
        e_son = 1'b1;
      end
    end
  endfunction

  // One clock: evaluate model on the pre-edge inputs, clock, then check outputs.
  task automatic step();
    logic [7:0] ev;
    int t;
    last_acc = 1'b0;
    e_son = 1'b0;
    if (rst_i) begin
      mdl_hazir = 0; mdl_hata = 0; mdl_yuklu = '0; m_need = 0; mdl_blk = 0;
      e_gec = 0; exp_q.delete(); rst_seen = 1;
    end else begin
      rst_seen = 0;
      last_acc = dqt_gecerli_i && mdl_hazir;
      e_gec = sorgu_gecerli_i;
      if (sorgu_gecerli_i) begin
        t = mdl_tablo();
        ev = mdl_yuklu[t] ? mdl_tab[t][int'(sorgu_row_i) * 8 + int'(sorgu_col_i)] : 8'd1;
        exp_q.push_back(ev);
        n_req++;
      end
      if (last_acc) model_byte(dqt_veri_i);
      if (cerceve_bas_i) mdl_blk = 0;
      else if (sorgu_gecerli_i && sorgu_blok_son_i) mdl_blk = (mdl_blk + 1) % mdl_n();
      mdl_hazir = 1;
    end
    @(posedge clk_i);
    #1;
    if (dqt_tablo_son_o === 1'b1) n_son++;
    if (sorgu_gecerli_o === 1'b1) n_resp++;
    chk("hazir", dqt_hazir_o, mdl_hazir);
    chk("tablo_son", dqt_tablo_son_o, e_son);
    chk("hata", dqt_hata_o, mdl_hata);
    chk("sorgu_gecerli", sorgu_gecerli_o, e_gec);
    if (rst_seen) chk("reset_deger", sorgu_deger_o, 0);
    if (e_gec) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
      else chk("sorgu_deger", sorgu_deger_o, exp_q.pop_front());
    end
    chk("aktif_bilesen", aktif_bilesen_o, mdl_bil());
    chk("aktif_tablo", aktif_tablo_o, mdl_tablo());
  endtask

  // ---------------- driver tasks ----------------
  task automatic quiet();
    dqt_gecerli_i = 0; sorgu_gecerli_i = 0; sorgu_blok_son_i = 0; cerceve_bas_i = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dqt_veri_i = b;
    dqt_gecerli_i = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", 0, 1);
    dqt_gecerli_i = 0;
  endtask

  task automatic lookup(input logic [2:0] r, input logic [2:0] c, input logic son);
    sorgu_row_i = r; sorgu_col_i = c; sorgu_gecerli_i = 1; sorgu_blok_son_i = son;
    step();
    sorgu_gecerli_i = 0; sorgu_blok_son_i = 0;
  endtask

  task automatic frame_start(input logic [2:0] y, input logic [1:0] bil, input logic [5:0] tab);
    cfg_y_blok_i = y; cfg_bilesen_i = bil; cfg_tablo_i = tab; cerceve_bas_i = 1;
    step();
    cerceve_bas_i = 0;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1;
    repeat (n) step();
    rst_i = 0;
    step();
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] byte_q[$];
  int s0;

  initial begin
    build_zz();
    t1_vec[0] = '{3'd0, 3'd1, 8'd2};
    t1_vec[1] = '{3'd1, 3'd0, 8'd3};
    t1_vec[2] = '{3'd2, 3'd0, 8'd4};
    t1_vec[3] = '{3'd7, 3'd7, 8'd64};
    t1_vec[4] = '{3'd0, 3'd0, 8'd1};
    t1_vec[5] = '{3'd0, 3'd2, 8'd6};
    t1_vec[6] = '{3'd7, 3'd0, 8'd36};
    t1_vec[7] = '{3'd0, 3'd7, 8'd29};
    t3_tab = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};

    quiet();
    dqt_veri_i = 0; sorgu_row_i = 0; sorgu_col_i = 0;
    cfg_y_blok_i = 3'd1; cfg_bilesen_i = 2'd1; cfg_tablo_i = 6'b100111;
    rst_i = 1;
    repeat (3) step();
    chk("rst_aktif_tablo", aktif_tablo_o, 3);
    chk("rst_durum", dbg_durum_o, 0);
    rst_i = 0;
    step();
    chk("hazir_after_first_cycle", dqt_hazir_o, 1);

    // 1: table 0 = 1..64 in zigzag order
    frame_start(3'd1, 2'd1, 6'b000000);
    s0 = n_son;
    send_byte(8'h00);
    for (int k = 0; k < 64; k++) send_byte(8'(k + 1));
    step();
    chk("t1_son_count", n_son - s0, 1);
    for (int i = 0; i < 8; i++) begin
      lookup(t1_vec[i].row, t1_vec[i].col, 1'b0);
      chk("t1_vec", sorgu_deger_o, t1_vec[i].exp);
    end
    for (int i = 0; i < 64; i++) lookup(3'(i / 8), 3'(i % 8), 1'b0);

    // 2: 16-bit table skipped with error, then table 1 = all 5
    send_byte(8'h10);
    for (int k = 0; k < 128; k++) send_byte(8'($urandom_range(0, 255)));
    chk("t2_hata", dqt_hata_o, 1);
    send_byte(8'h01);
    for (int k = 0; k < 64; k++) send_byte(8'h05);
    chk("t2_hata_sticky", dqt_hata_o, 1);
    for (int i = 0; i < 8; i++) begin
      lookup(t1_vec[i].row, t1_vec[i].col, 1'b0);
      chk("t2_tab0_untouched", sorgu_deger_o, t1_vec[i].exp);
    end
    frame_start(3'd1, 2'd1, 6'b000001);
    for (int i = 0; i < 64; i++) begin
      lookup(3'(i / 8), 3'(i % 8), 1'b0);
      chk("t2_tab1", sorgu_deger_o, 5);
    end

    // 3: 4:2:0 MCU, 14 blocks of 64 coefficients
    frame_start(3'd4, 2'd3, 6'b010100);
    for (int b = 0; b < 14; b++) begin
      chk("t3_blok_tablo", aktif_tablo_o, t3_tab[b]);
      for (int c = 0; c < 64; c++) lookup(3'(c / 8), 3'(c % 8), c == 63);
    end

    // 4: unloaded table reads identity; reload collides with read of same entry
    frame_start(3'd1, 2'd1, 6'b000011);
    lookup(3'd0, 3'd0, 1'b0);
    chk("t4_unloaded", sorgu_deger_o, 1);
    frame_start(3'd1, 2'd1, 6'b000001);
    send_byte(8'h01);
    sorgu_row_i = 0; sorgu_col_i = 0; sorgu_gecerli_i = 1;
    send_byte(8'hAA);
    sorgu_gecerli_i = 0;
    chk("t4_old_value", sorgu_deger_o, 5);
    lookup(3'd0, 3'd0, 1'b0);
    chk("t4_new_value", sorgu_deger_o, 8'hAA);
    for (int k = 1; k < 64; k++) send_byte(8'($urandom_range(0, 255)));

    // 5a: frame start wins over a coincident block-last at blk=2
    frame_start(3'd2, 2'd3, 6'b100100);
    lookup(3'd0, 3'd0, 1'b1);
    lookup(3'd0, 3'd0, 1'b1);
    chk("t5_blk2_bilesen", aktif_bilesen_o, 1);
    sorgu_gecerli_i = 1; sorgu_blok_son_i = 1; cerceve_bas_i = 1;
    step();
    quiet();
    chk("t5_cerceve_bilesen", aktif_bilesen_o, 0);
    lookup(3'd0, 3'd0, 1'b1);
    chk("t5_after_bilesen", aktif_bilesen_o, 0);

    // 5b: reset in the middle of a table load
    frame_start(3'd1, 2'd1, 6'b000010);
    send_byte(8'h02);
    for (int k = 0; k < 30; k++) send_byte(8'($urandom_range(0, 255)));
    do_reset(1);
    lookup(3'd3, 3'd4, 1'b0);
    chk("t5_abandoned", sorgu_deger_o, 1);
    s0 = n_son;
    send_byte(8'h02);
    for (int k = 0; k < 64; k++) send_byte(8'($urandom_range(0, 255)));
    chk("t5_reload_son", n_son - s0, 1);
    for (int i = 0; i < 8; i++) lookup(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);

    // 6: random segments interleaved with lookups; the first stretch requests every cycle
    frame_start(3'd2, 2'd3, 6'($urandom_range(0, 63)));
    for (int g = 0; g < 8; g++) begin
      int r = $urandom_range(0, 9);
      logic [7:0] h;
      if (r < 6)      h = {4'h0, 4'($urandom_range(0, 3))};
      else if (r < 8) h = {4'h0, 4'($urandom_range(4, 15))};
      else            h = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
      byte_q.push_back(h);
      for (int k = 0; k < ((h[7:4] == 4'd0) ? 64 : 128); k++) byte_q.push_back(8'($urandom_range(0, 255)));
    end
    for (int cyc = 0; cyc < 1500 && byte_q.size() > 0; cyc++) begin
      dqt_gecerli_i = ($urandom_range(0, 3) != 0);
      dqt_veri_i = byte_q[0];
      sorgu_gecerli_i = (cyc < 300) ? 1'b1 : ($urandom_range(0, 7) != 0);
      sorgu_row_i = 3'($urandom_range(0, 7));
      sorgu_col_i = 3'($urandom_range(0, 7));
      sorgu_blok_son_i = ($urandom_range(0, 7) == 0);
      cerceve_bas_i = ($urandom_range(0, 99) == 0);
      step();
      if (last_acc) void'(byte_q.pop_front());
    end
    if (byte_q.size() != 0) chk("t6_stream_timeout", byte_q.size(), 0);
    quiet();
    step();
    step();
    chk("t6_req_resp", n_resp, n_req);
    chk("end_durum_bosta", dbg_durum_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
